// File: rtl/ahb_gpio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ahb_gpio_bridge
// Purpose  : AHB-Lite slave that turns word transfers into single-cycle
//            strobes for a simple register-based GPIO core. Writes are zero
//            wait, reads take one wait state, bad transfers get a two-cycle
//            ERROR response and never touch the core.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_gpio_bridge #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             HSEL,
  input  logic [WIDTH-1:0] HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [WIDTH-1:0] HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [WIDTH-1:0] HRDATA,
  output logic             sel,
  output logic             w_en,
  output logic             r_en,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rdata_in
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd1;
  localparam logic [2:0] S_READ_WAIT = 3'd2;
  localparam logic [2:0] S_READ_RESP = 3'd3;
  localparam logic [2:0] S_ERR1      = 3'd4;
  localparam logic [2:0] S_ERR2      = 3'd5;

  // Number of implemented registers, sized to compare against a word index
  localparam logic [WIDTH-1:0] REG_LIMIT = WIDTH'(NUM_REGS);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [WIDTH-1:0] reg_idx;
  logic             reg_write;
  logic             reg_err;

  logic             ready_state;
  logic             accept;
  logic [WIDTH-1:0] word_idx;
  logic             addr_err;

  // HTRANS[0] only distinguishes SEQ from NONSEQ, which this slave treats alike
  logic             unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  // The slave only stalls the bus in READ_WAIT and ERR1; everywhere else a
  // new address phase may be taken, giving back-to-back pipelining.
  assign ready_state = (state != S_READ_WAIT) && (state != S_ERR1);
  assign accept      = HSEL & HREADY & HTRANS[1] & ready_state;

  assign word_idx = {2'b00, HADDR[WIDTH-1:2]};
  assign addr_err = (word_idx >= REG_LIMIT) || (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00);

  // Next-state selection; accepted transfers are decoded from the live address phase
  always_comb begin
    next_state = state;
    case (state)
      S_READ_WAIT: next_state = S_READ_RESP;
      S_ERR1:      next_state = S_ERR2;
      default: begin
        if (accept) begin
          if (addr_err)    next_state = S_ERR1;
          else if (HWRITE) next_state = S_WRITE;
          else             next_state = S_READ_WAIT;
        end else begin
          next_state = S_IDLE;
        end
      end
    endcase
  end

  // State register plus address-phase capture of index, direction and error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      reg_idx   <= '0;
      reg_write <= 1'b0;
      reg_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        reg_idx   <= word_idx;
        reg_write <= HWRITE;
        reg_err   <= addr_err;
      end
    end
  end

  // Read data is sampled from the core at the end of the wait state and held
  // until the next read completes, so reset mid-read leaves it cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HRDATA <= '0;
    end else if (state == S_READ_WAIT) begin
      HRDATA <= rdata_in;
    end
  end

  // Core-side strobes and bus response decoded from the current state. The
  // registered error/direction flags are also folded in so a core access can
  // never coincide with an erroring transfer.
  always_comb begin
    sel       = ((state == S_WRITE) || (state == S_READ_WAIT)) && !reg_err;
    w_en      = sel && (state == S_WRITE) && reg_write;
    r_en      = sel && (state == S_READ_WAIT) && !reg_write;
    addr      = sel ? reg_idx : '0;
    wdata     = w_en ? HWDATA : '0;
    HREADYOUT = ready_state;
    HRESP     = (state == S_ERR1) || (state == S_ERR2);
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_gpio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_gpio_bridge
// Purpose  : Directed self-checking bench for ahb_gpio_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_gpio_bridge;

  logic        clk;
  logic        reset;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        sel;
  logic        w_en;
  logic        r_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_in;

  int checks;
  int failures;

  // Single-slave bus: the bus-wide ready is this slave's ready
  assign HREADY = HREADYOUT;

  ahb_gpio_bridge #(.WIDTH(32), .NUM_REGS(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .sel       (sel),
    .w_en      (w_en),
    .r_en      (r_en),
    .addr      (addr),
    .wdata     (wdata),
    .rdata_in  (rdata_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic aphase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = a;
    HWRITE = wr;
    HSIZE  = sz;
  endtask

  task automatic idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HADDR  = 32'h0;
    HWRITE = 1'b0;
    HSIZE  = 3'b010;
  endtask

  // Checks the two-cycle error response that follows an erroring address phase
  task automatic err_seq(input string tag);
    step(); idle(); #1;
    chk({tag, "_e1_hresp"}, {31'b0, HRESP}, 32'd1);
    chk({tag, "_e1_hready"}, {31'b0, HREADYOUT}, 32'd0);
    chk({tag, "_e1_strobes"}, {29'b0, sel, w_en, r_en}, 32'd0);
    step(); #1;
    chk({tag, "_e2_hresp"}, {31'b0, HRESP}, 32'd1);
    chk({tag, "_e2_hready"}, {31'b0, HREADYOUT}, 32'd1);
    chk({tag, "_e2_strobes"}, {29'b0, sel, w_en, r_en}, 32'd0);
    step(); #1;
    chk({tag, "_after_hresp"}, {31'b0, HRESP}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    HWDATA   = 32'h0;
    rdata_in = 32'h0;
    idle();

    // Reset state
    #3;
    chk("rst_hready", {31'b0, HREADYOUT}, 32'd1);
    chk("rst_hresp", {31'b0, HRESP}, 32'd0);
    chk("rst_strobes", {29'b0, sel, w_en, r_en}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    step();
    step();
    #4 reset = 1'b0;

    // Single write to 0x08
    step(); aphase(32'h08, 1'b1, 3'b010); #1;
    step(); idle(); HWDATA = 32'hFFFF_FFFE; #1;
    chk("wr_strobes", {29'b0, sel, w_en, r_en}, 32'b110);
    chk("wr_addr", addr, 32'd2);
    chk("wr_wdata", wdata, 32'hFFFF_FFFE);
    chk("wr_hready", {31'b0, HREADYOUT}, 32'd1);
    chk("wr_hresp", {31'b0, HRESP}, 32'd0);
    step(); #1;
    chk("wr_done_wen", {31'b0, w_en}, 32'd0);
    chk("wr_done_wdata_gated", wdata, 32'd0);

    // Single read from 0x0C
    aphase(32'h0C, 1'b0, 3'b010);
    step(); idle(); rdata_in = 32'h0000_0021; #1;
    chk("rd_wait_strobes", {29'b0, sel, w_en, r_en}, 32'b101);
    chk("rd_wait_addr", addr, 32'd3);
    chk("rd_wait_hready", {31'b0, HREADYOUT}, 32'd0);
    step(); #1;
    chk("rd_resp_hrdata", HRDATA, 32'h0000_0021);
    chk("rd_resp_hready", {31'b0, HREADYOUT}, 32'd1);
    chk("rd_resp_ren", {31'b0, r_en}, 32'd0);
    rdata_in = 32'h1234_5678;
    step(); #1;
    chk("rd_hold_hrdata", HRDATA, 32'h0000_0021);

    // Back-to-back writes to 0x04 then 0x10
    aphase(32'h04, 1'b1, 3'b010);
    step(); aphase(32'h10, 1'b1, 3'b010); HWDATA = 32'h0000_0011; #1;
    chk("b2b_w1_wen", {31'b0, w_en}, 32'd1);
    chk("b2b_w1_addr", addr, 32'd1);
    chk("b2b_w1_wdata", wdata, 32'h0000_0011);
    step(); idle(); HWDATA = 32'h0000_0022; #1;
    chk("b2b_w2_wen", {31'b0, w_en}, 32'd1);
    chk("b2b_w2_addr", addr, 32'd4);
    chk("b2b_w2_wdata", wdata, 32'h0000_0022);
    chk("b2b_w2_hready", {31'b0, HREADYOUT}, 32'd1);
    step(); #1;
    chk("b2b_done_wen", {31'b0, w_en}, 32'd0);

    // Highest valid index (5) is accepted as a normal read
    aphase(32'h14, 1'b0, 3'b010);
    step(); idle(); rdata_in = 32'h0000_0055; #1;
    chk("idx5_ren", {31'b0, r_en}, 32'd1);
    chk("idx5_hresp", {31'b0, HRESP}, 32'd0);
    step(); #1;
    chk("idx5_hrdata", HRDATA, 32'h0000_0055);

    // Error cases: out-of-range index, misaligned, wrong size
    aphase(32'h18, 1'b0, 3'b010);
    err_seq("err_idx6");
    aphase(32'h05, 1'b1, 3'b010);
    err_seq("err_misalign");
    aphase(32'h04, 1'b0, 3'b000);
    err_seq("err_size");

    // A new transfer may be accepted during ERR2
    aphase(32'h18, 1'b1, 3'b010);
    step(); idle(); #1;
    chk("err_pipe_e1", {31'b0, HRESP}, 32'd1);
    step(); aphase(32'h00, 1'b1, 3'b010); #1;
    chk("err_pipe_e2", {31'b0, HRESP}, 32'd1);
    step(); idle(); HWDATA = 32'hCAFE_0000; #1;
    chk("err_pipe_wen", {31'b0, w_en}, 32'd1);
    chk("err_pipe_addr", addr, 32'd0);
    chk("err_pipe_hresp", {31'b0, HRESP}, 32'd0);

    // BUSY transfer and HSEL=0 are ignored
    step(); aphase(32'h08, 1'b1, 3'b010); HTRANS = 2'b01; #1;
    step(); idle(); #1;
    chk("busy_ignored", {29'b0, sel, w_en, r_en}, 32'd0);
    chk("busy_hready", {31'b0, HREADYOUT}, 32'd1);
    aphase(32'h08, 1'b1, 3'b010); HSEL = 1'b0;
    step(); idle(); #1;
    chk("nosel_ignored", {29'b0, sel, w_en, r_en}, 32'd0);

    // Reset asserted in the middle of READ_WAIT
    aphase(32'h08, 1'b0, 3'b010);
    step(); idle(); rdata_in = 32'hDEAD_BEEF; #1;
    chk("rstmid_pre_ren", {31'b0, r_en}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_strobes", {29'b0, sel, w_en, r_en}, 32'd0);
    chk("rstmid_hready", {31'b0, HREADYOUT}, 32'd1);
    chk("rstmid_addr", addr, 32'd0);
    chk("rstmid_hrdata", HRDATA, 32'd0);
    step();
    #3 reset = 1'b0;
    step(); #1;
    chk("rstmid_after_hready", {31'b0, HREADYOUT}, 32'd1);
    chk("rstmid_after_hrdata", HRDATA, 32'd0);
    chk("rstmid_after_strobes", {29'b0, sel, w_en, r_en}, 32'd0);

    // Write then read of the same index
    aphase(32'h04, 1'b1, 3'b010);
    step(); aphase(32'h04, 1'b0, 3'b010); HWDATA = 32'hA5A5_A5A5; #1;
    chk("raw_w_wen", {31'b0, w_en}, 32'd1);
    chk("raw_w_addr", addr, 32'd1);
    chk("raw_w_wdata", wdata, 32'hA5A5_A5A5);
    step(); idle(); rdata_in = 32'hA5A5_A5A5; #1;
    chk("raw_r_strobes", {29'b0, sel, w_en, r_en}, 32'b101);
    chk("raw_r_addr", addr, 32'd1);
    chk("raw_r_hready", {31'b0, HREADYOUT}, 32'd0);
    step(); #1;
    chk("raw_r_hrdata", HRDATA, 32'hA5A5_A5A5);
    chk("raw_r_hready_resp", {31'b0, HREADYOUT}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_gpio_bridge.md
AHB_GPIO_BRIDGE -- requirements
Module: ahb_gpio_bridge

Interface
REQ-001 SHALL have parameters: WIDTH, 32, data/address width; NUM_REGS, 6, number of valid word registers in the downstream GPIO core (index 0..NUM_REGS-1).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- HSEL  in  1  AHB slave select.
- HADDR  in  WIDTH  AHB byte address.
- HTRANS  in  2  AHB transfer type; bit 1 set = NONSEQ/SEQ.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  transfer size.
- HWDATA  in  WIDTH  write data, valid in data phase.
- HREADY  in  1  bus-wide ready.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  WIDTH  read data.
- sel  out  1  core select.
- w_en  out  1  core write strobe.
- r_en  out  1  core read strobe.
- addr  out  WIDTH  core word index.
- wdata  out  WIDTH  core write data.
- rdata_in  in  WIDTH  core read data, combinational from addr/r_en.

Function
REQ-003 SHALL accept an address phase when HSEL & HREADY & HTRANS[1] are all 1 on a rising clk edge.
- On acceptance, SHALL register HWRITE, the word index HADDR[WIDTH-1:2] zero-extended, and the error flag.
REQ-004 Error flag SHALL be 1 if any of these hold: word index >= NUM_REGS; HSIZE != 3'b010; HADDR[1:0] != 0.
REQ-005 SHALL implement FSM states IDLE, WRITE, READ_WAIT, READ_RESP, ERR1, ERR2.
REQ-006 Transitions SHALL be as follows.
- An accepted transfer with error flag set goes to ERR1.
- Otherwise, an accepted write goes to WRITE.
- Otherwise, an accepted read goes to READ_WAIT.
- With no acceptance, the FSM goes to IDLE from IDLE, WRITE, READ_RESP or ERR2.
- READ_WAIT always goes to READ_RESP.
- ERR1 always goes to ERR2.
REQ-007 Acceptance SHALL be evaluated only in states where HREADYOUT=1: IDLE, WRITE, READ_RESP, ERR2.
- This allows back-to-back pipelined transfers with no idle cycle.
REQ-008 WRITE (zero wait): SHALL drive sel=1, w_en=1, addr=registered index, wdata=HWDATA, HREADYOUT=1, HRESP=0 combinationally in that cycle.
- The core captures on the closing edge, so write latency is 1 cycle after the address phase.
REQ-009 READ_WAIT: SHALL drive sel=1, r_en=1, addr=registered index, HREADYOUT=0, HRESP=0.
- SHALL register rdata_in into HRDATA at the closing edge.
REQ-010 READ_RESP: HREADYOUT=1, HRESP=0, HRDATA SHALL hold the captured value.
- Read latency is 2 cycles from the address phase, with exactly one wait state.
REQ-011 ERR1 SHALL drive HRESP=1, HREADYOUT=0.
REQ-012 ERR2 SHALL drive HRESP=1, HREADYOUT=1.
REQ-013 In ERR1/ERR2, sel, w_en and r_en SHALL be 0, so no core access occurs.
REQ-014 HRDATA SHALL hold its last value outside READ_RESP; in IDLE, HREADYOUT=1 and HRESP=0.
REQ-015 sel, w_en and r_en SHALL be 0 in every state other than those stated, and w_en and r_en SHALL never both be 1.
REQ-016 IDLE/BUSY transfers (HTRANS[1]=0) and HSEL=0 SHALL be ignored; they receive an OKAY zero-wait response.
REQ-017 wdata SHALL be 0 when w_en=0.

Reset
REQ-018 While reset=1, asynchronously and without waiting for clk:
- FSM=IDLE; HRDATA=0; HREADYOUT=1; HRESP=0; sel=w_en=r_en=0; addr=0; registered index, write flag and error flag = 0.
REQ-019 If reset asserts mid-transfer, the transfer SHALL be abandoned with no core strobe on the following edge.
- The first cycle after deassertion SHALL be IDLE.

Verification
REQ-020 Write: HADDR=0x08, HWRITE=1, HSIZE=2, then HWDATA=0xFFFFFFFE.
- Next cycle: sel=w_en=1, addr=2, wdata=0xFFFFFFFE, HREADYOUT=1, HRESP=0.
REQ-021 Read: HADDR=0x0C, HWRITE=0, rdata_in=0x00000021.
- Cycle+1: r_en=1, addr=3, HREADYOUT=0.
- Cycle+2: HRDATA=0x00000021, HREADYOUT=1.
REQ-022 Back-to-back: writes to 0x04 and 0x10 in consecutive address phases.
- Two consecutive w_en pulses with addr=1 then addr=4, no wait states.
REQ-023 Errors: HADDR=0x18 (index 6), HADDR=0x05, or HSIZE=0.
- Each gives HRESP=1 for 2 cycles, with HREADYOUT 0 then 1, and no sel/w_en/r_en.
REQ-024 Reset in READ_WAIT: assert reset mid-cycle.
- Outputs go immediately to reset values; after release, HREADYOUT=1 and no stale HRDATA update.
REQ-025 Read immediately after write to the same index (0x04 write 0xA5A5A5A5, then read 0x04).
- w_en cycle, then r_en cycle; HRDATA equals the rdata_in presented during READ_WAIT.
